// File: rtl/panda_pkg.sv
// Panda core shared types for the fetch/decode boundary.
// Holds the IF->ID bundle, the prefetch FIFO entry and the alignment mask.
package panda_pkg;

  localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_inc;
  } if_id_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_inc;
  } fetch_entry_t;

endpackage

// File: rtl/panda_fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t, power-of-two Depth, flush beats push.
// Ports: push_i/data_i, pop_i/data_o (head), flush_i, full_o, empty_o, count_o.
module panda_fetch_fifo
  import panda_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               data_i,
  input  logic                       pop_i,
  output fetch_entry_t               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = $clog2(Depth + 1);

  fetch_entry_t  mem_q [Depth];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken alongside a pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/panda_prefetch_if.sv
// Panda IF stage: req/gnt/rvalid fetch, prefetch FIFO, redirect flush.
// Ports: instr_* memory port, branch/jump redirect, id_ready_i/if_valid_o/if_id_o.
// Optional PANDA_IF_PERF_EN adds perf_fetched_o and perf_stall_o counters.
module panda_prefetch_if
  import panda_pkg::*;
#(
  parameter int unsigned Depth          = 2,
  parameter int unsigned MaxOutstanding = 2,
  parameter logic [31:0] BootAddr       = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] jump_target_i,
  input  logic        id_ready_i,
  output logic        if_valid_o,
  output if_id_t      if_id_o
`ifdef PANDA_IF_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stall_o
`endif
);

  localparam int unsigned OW = $clog2(MaxOutstanding + 1);
  localparam int unsigned DW = $clog2(MaxOutstanding + 2);
  localparam int unsigned CW = $clog2(Depth + 1);

  logic          active_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   fetch_pc_d;
  logic [OW-1:0] outst_q;
  logic [OW-1:0] outst_d;
  logic [DW-1:0] disc_q;
  logic [DW-1:0] disc_d;
  logic          rpend_q;
  logic          rpend_d;
  logic [31:0]   rtgt_q;
  logic [31:0]   rtgt_d;
  logic [31:0]   pcq_q [MaxOutstanding];

  logic          gnt_ok;
  logic          hold;
  logic          rsp;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          redirect;
  logic [31:0]   tgt;
  logic          credit;
  logic [OW-1:0] wr_idx;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;
  fetch_entry_t  fifo_in;
  fetch_entry_t  fifo_head;

  assign gnt_ok   = instr_req_o & instr_gnt_i;
  assign hold     = instr_req_o & ~instr_gnt_i;
  // rvalid with nothing in flight is ignored rather than underflowing.
  assign rsp      = instr_rvalid_i & (outst_q != '0);
  assign rsp_drop = rsp & (disc_q != '0);
  assign rsp_keep = rsp & (disc_q == '0);
  assign redirect = branch_i | jump_i;
  assign tgt      = (branch_i ? branch_target_i : jump_target_i)
                  & INSTR_ALIGN_MASK;

  // Credits cover both buffered and in-flight words, so a response
  // always finds a free FIFO slot.
  assign credit = (32'(fifo_cnt) + 32'(outst_q) < 32'(Depth))
                & (32'(outst_q) < 32'(MaxOutstanding));

  // active_q keeps the request low throughout reset.
  assign instr_req_o  = active_q & credit;
  assign instr_addr_o = fetch_pc_q;

  always_comb begin
    outst_d = outst_q;
    unique case ({gnt_ok, rsp})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
  end

  // Everything in flight at a redirect is stale, plus a held request
  // that must still be granted at its old address.
  always_comb begin
    disc_d = disc_q;
    if (rsp_drop) begin
      disc_d = disc_q - DW'(1);
    end
    if (redirect) begin
      disc_d = DW'(outst_d) + DW'(hold);
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rpend_d    = rpend_q;
    rtgt_d     = rtgt_q;
    if (redirect) begin
      if (hold) begin
        rpend_d = 1'b1;
        rtgt_d  = tgt;
      end else begin
        fetch_pc_d = tgt;
        rpend_d    = 1'b0;
      end
    end else if (gnt_ok) begin
      if (rpend_q) begin
        fetch_pc_d = rtgt_q;
        rpend_d    = 1'b0;
      end else begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q   <= 1'b0;
      fetch_pc_q <= BootAddr;
      outst_q    <= '0;
      disc_q     <= '0;
      rpend_q    <= 1'b0;
      rtgt_q     <= '0;
    end else begin
      active_q   <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      rpend_q    <= rpend_d;
      rtgt_q     <= rtgt_d;
    end
  end

  // In-order address queue; entry 0 is the oldest in-flight request.
  // Dropped responses pop it too, so it never needs flushing.
  assign wr_idx = outst_q - OW'(rsp);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        pcq_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(MaxOutstanding) - 1; i++) begin
        if (rsp) begin
          pcq_q[i] <= pcq_q[i+1];
        end
      end
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        if (gnt_ok && (OW'(i) == wr_idx)) begin
          pcq_q[i] <= fetch_pc_q;
        end
      end
    end
  end

  assign fifo_in.instr  = instr_rdata_i;
  assign fifo_in.pc     = pcq_q[0];
  assign fifo_in.pc_inc = pcq_q[0] + 32'd4;

  assign fifo_pop  = if_valid_o & id_ready_i;
  assign fifo_push = rsp_keep & (~fifo_full | fifo_pop);

  panda_fetch_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect),
    .push_i  (fifo_push),
    .data_i  (fifo_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign if_valid_o = ~fifo_empty;

  always_comb begin
    if_id_o = '0;
    if (!fifo_empty) begin
      if_id_o.instr  = fifo_head.instr;
      if_id_o.pc     = fifo_head.pc;
      if_id_o.pc_inc = fifo_head.pc_inc;
    end
  end

`ifdef PANDA_IF_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;
  logic        starve;

  assign starve = id_ready_i & ~if_valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (fifo_pop && (perf_fetched_q != 32'hFFFF_FFFF)) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (starve && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: doc/panda_prefetch_if.md
Name: panda_prefetch_if

Overview:
- Next-generation instruction-fetch stage for the Panda core.
- Replaces the fixed single-cycle fetch with a req/gnt/rvalid instruction-memory handshake.
- Adds a parametrised prefetch FIFO, multiple outstanding requests, decode back-pressure and redirect flush.
- Sits between the instruction memory port and the ID stage; produces the panda_pkg::if_id_t payload plus a valid flag.

Parameters:
- Depth, 2: prefetch FIFO entries; power of two, >= 2.
- MaxOutstanding, 2: maximum granted-but-not-returned requests; 1..Depth.
- BootAddr, 32'h0000_0000: fetch address after reset; must be word aligned.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active low
- instr_req_o  out  1  fetch request
- instr_gnt_i  in  1  request accepted this cycle
- instr_addr_o  out  32  fetch address, word aligned
- instr_rvalid_i  in  1  response data valid; in-order, at least 1 cycle after grant
- instr_rdata_i  in  32  response instruction
- branch_i  in  1  redirect to branch_target_i
- jump_i  in  1  redirect to jump_target_i
- branch_target_i  in  32  branch target
- jump_target_i  in  32  jump target
- id_ready_i  in  1  ID accepts if_id_o this cycle
- if_valid_o  out  1  if_id_o holds a valid instruction
- if_id_o  out  if_id_t  {instr, pc, pc_inc}

Behaviour:
- Reset values (async): instr_req_o=0, instr_addr_o=BootAddr, if_valid_o=0, if_id_o all zero, FIFO empty, outstanding=0, discard=0.
- Request issue:
  - instr_req_o=1 when (fifo_count + outstanding) < Depth and outstanding < MaxOutstanding.
  - Once asserted without a grant, instr_req_o and instr_addr_o hold stable until instr_gnt_i.
  - On req&gnt: outstanding+1 and fetch_pc += 4, wrapping modulo 2^32.
  - Back-to-back grants are allowed.
- Response:
  - instr_rvalid_i with discard==0: outstanding-1 and push {instr_rdata_i, pc, pc+4} into the FIFO, where pc is the address of the oldest outstanding request.
  - Grant and rvalid in the same cycle: outstanding stays unchanged.
- Output:
  - FIFO head is registered into if_id_o/if_valid_o.
  - Minimum latency is grant -> rvalid (1 cycle) -> if_valid_o (next cycle).
  - Pop when if_valid_o & id_ready_i.
  - Without id_ready_i, if_id_o holds its value.
- Full/empty:
  - Push when full never occurs, because the credit rule prevents it.
  - Push and pop in the same cycle when full is legal.
  - Pop when empty deasserts if_valid_o.
- Redirect (branch_i | jump_i):
  - branch_i has priority over jump_i when both are set.
  - Next cycle: FIFO empty, if_valid_o=0, fetch_pc=target.
  - discard = outstanding (after accounting for same-cycle gnt/rvalid), plus 1 if a request is pending without a grant.
- Pending ungranted request at redirect: it completes with its old address and its response is dropped; the new target is issued after that grant.
- While discard>0: each rvalid decrements discard and its data is dropped. New requests may issue meanwhile; responses return in order.
- Redirect targets: bits [1:0] are ignored (forced to 0).
- Reset mid-operation: all state returns to reset values immediately; late responses after reset are out of contract.

Optional Feature:
- PANDA_IF_PERF_EN defined:
  - Adds outputs perf_fetched_o[31:0] (count of FIFO pops) and perf_stall_o[31:0] (cycles with id_ready_i=1 and if_valid_o=0).
  - Both counters are reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters do not exist.

Decomposition:
- panda_pkg:
  - keeps if_id_t;
  - adds fetch_entry_t {instr, pc, pc_inc};
  - adds constant INSTR_ALIGN_MASK=32'hFFFF_FFFC.
- Sub-module panda_fetch_fifo (parameter Depth, element fetch_entry_t):
  - ports push, pop, flush, full, empty, count;
  - flush has priority over push.
- Top-level logic: credit/outstanding counters, discard counter, pc tracking queue (MaxOutstanding entries), redirect logic.

Test Plan:
- Reset release, gnt and rvalid always 1, id_ready=1 -> addr 0,4,8,... and if_valid_o rises 2 cycles after the first request; pc_inc = pc+4.
- id_ready=0 for 10 cycles with Depth=2 -> at most 2 entries buffered, instr_req_o drops, if_id_o stable; release -> all instructions delivered in order, none lost.
- gnt held 0 for 3 cycles -> instr_addr_o stable at 0x8; grant -> next addr 0xC.
- branch_i with target 0x100 while 2 requests are outstanding -> the 2 old rvalids are dropped and the next delivered pc is 0x100.
- branch_i and jump_i together, targets 0x200/0x300 -> fetch resumes at 0x200; redirect on the same cycle as rvalid -> that data is dropped.
- PANDA_IF_PERF_EN: 5 pops and 3 starved cycles -> perf_fetched_o=5, perf_stall_o=3.
